// File: rtl/tube_init_pkg.sv
// Shared types and helpers for the Tube parasite-side bus initiator.
package tube_init_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_STAT,
        S_RD,
        S_WR
    } state_t;

    localparam int ST_AVAIL   = 7;
    localparam int ST_NOTFULL = 6;

    // Each channel owns a status/data register pair.
    function automatic logic [2:0] chan_addr(
        input logic [1:0] chan,
        input logic       is_data
    );
        return {chan, is_data};
    endfunction

endpackage

// File: rtl/tube_init_fifo.sv
// Synchronous RX FIFO: push, pop, occupancy count and head byte.
module tube_init_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [7:0]               push_data,
    input  logic                     pop,
    output logic [7:0]               head,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign do_pop  = pop && (count != '0);
    assign do_push = push && (count != FULL);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/tube_p_initiator.sv
// Parasite-side Tube register bus master: polls status, moves RX/TX bytes.
// Build option TUBE_IRQ_WAKE_EN: idle engine sleeps until IRQ or pending TX.
module tube_p_initiator
    import tube_init_pkg::*;
#(
    parameter int RX_DEPTH = 4,
    parameter int IDLE_GAP = 2
) (
    input  logic       p_phi2,
    input  logic       p_rst,
    input  logic [1:0] chan,
    output logic [2:0] p_addr,
    output logic       p_cs_b,
    output logic       p_rdnw,
    output logic [7:0] p_data_out,
    input  logic [7:0] p_data_in,
    input  logic       p_irq_b,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       busy
);

    localparam int CW = $clog2(RX_DEPTH) + 1;
    localparam logic [CW-1:0] RX_FULL  = CW'(RX_DEPTH);
    localparam logic [3:0]    GAP_INIT = 4'(IDLE_GAP);

    state_t        state;
    state_t        nxt;
    logic [1:0]    chan_q;
    logic [1:0]    chan_n;
    logic [3:0]    gap;
    logic [3:0]    gap_n;
    logic          prio;
    logic          prio_n;
    logic [7:0]    hold;
    logic          hold_valid;
    logic [CW-1:0] rx_count;
    logic          rx_ok;
    logic          tx_ok;
    logic          wake;

`ifdef TUBE_IRQ_WAKE_EN
    assign wake = !p_irq_b || hold_valid;
`else
    logic unused_irq;
    assign unused_irq = p_irq_b;
    assign wake       = 1'b1;
`endif

    assign busy     = (state != S_IDLE);
    assign tx_ready = !hold_valid;
    assign rx_valid = (rx_count != '0);

    always_comb begin
        nxt    = state;
        gap_n  = gap;
        prio_n = prio;
        chan_n = chan_q;
        rx_ok  = p_data_in[ST_AVAIL] && (rx_count != RX_FULL);
        tx_ok  = p_data_in[ST_NOTFULL] && hold_valid;
        unique case (state)
            S_IDLE: begin
                gap_n = (gap == 4'd0) ? 4'd0 : gap - 4'd1;
                // Leave as the count reaches zero so IDLE_GAP idle cycles occur.
                if ((gap <= 4'd1) && wake) begin
                    nxt    = S_STAT;
                    chan_n = chan;
                end
            end
            S_STAT: begin
                if (rx_ok && tx_ok) begin
                    nxt    = prio ? S_WR : S_RD;
                    prio_n = !prio;
                end else if (rx_ok) begin
                    nxt = S_RD;
                end else if (tx_ok) begin
                    nxt = S_WR;
                end else begin
                    nxt   = S_IDLE;
                    gap_n = GAP_INIT;
                end
            end
            S_RD:    nxt = S_STAT;
            S_WR:    nxt = S_STAT;
            default: nxt = S_IDLE;
        endcase
    end

    // Bus outputs are registered from the next state.
    always_ff @(posedge p_phi2 or posedge p_rst) begin
        if (p_rst) begin
            state      <= S_IDLE;
            gap        <= 4'd0;
            prio       <= 1'b0;
            chan_q     <= 2'd0;
            p_cs_b     <= 1'b1;
            p_rdnw     <= 1'b1;
            p_addr     <= 3'd0;
            p_data_out <= 8'h00;
        end else begin
            state      <= nxt;
            gap        <= gap_n;
            prio       <= prio_n;
            chan_q     <= chan_n;
            p_cs_b     <= (nxt == S_IDLE);
            p_rdnw     <= (nxt != S_WR);
            p_addr     <= chan_addr(chan_n, (nxt == S_RD) || (nxt == S_WR));
            p_data_out <= (nxt == S_WR) ? hold : 8'h00;
        end
    end

    always_ff @(posedge p_phi2 or posedge p_rst) begin
        if (p_rst) begin
            hold       <= 8'h00;
            hold_valid <= 1'b0;
        end else if (state == S_WR) begin
            hold_valid <= 1'b0;
        end else if (tx_valid && !hold_valid) begin
            hold       <= tx_data;
            hold_valid <= 1'b1;
        end
    end

    tube_init_fifo #(
        .DEPTH(RX_DEPTH)
    ) u_fifo (
        .clk      (p_phi2),
        .rst      (p_rst),
        .push     (state == S_RD),
        .push_data(p_data_in),
        .pop      (rx_ready),
        .head     (rx_data),
        .count    (rx_count)
    );

endmodule

// File: tb/tb_tube_p_initiator.sv
// Directed bench for tube_p_initiator: vector table plus corner sequences.
module tb_tube_p_initiator;

    logic       p_phi2;
    logic       p_rst;
    logic [1:0] chan;
    logic [2:0] p_addr;
    logic       p_cs_b;
    logic       p_rdnw;
    logic [7:0] p_data_out;
    logic [7:0] p_data_in;
    logic       p_irq_b;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       busy;

    logic [7:0] stat_v;
    logic [7:0] dat_v;
    int         checks;
    int         errors;
    int         nreads;
    int         acc;
    logic       found;

    tube_p_initiator dut (
        .p_phi2    (p_phi2),
        .p_rst     (p_rst),
        .chan      (chan),
        .p_addr    (p_addr),
        .p_cs_b    (p_cs_b),
        .p_rdnw    (p_rdnw),
        .p_data_out(p_data_out),
        .p_data_in (p_data_in),
        .p_irq_b   (p_irq_b),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .busy      (busy)
    );

    // Tube model: odd addresses are data registers, even are status.
    assign p_data_in = p_addr[0] ? dat_v : stat_v;

    initial p_phi2 = 1'b0;
    always #5 p_phi2 = ~p_phi2;

    typedef struct {
        bit         rst;
        logic [1:0] chan;
        logic [7:0] stat;
        logic [7:0] dat;
        bit         txv;
        logic [7:0] txd;
        bit         rxr;
        bit         e_cs_b;
        logic [2:0] e_addr;
        bit         e_rdnw;
        logic [7:0] e_dout;
        bit         e_rxv;
        logic [7:0] e_rxd;
        bit         e_txr;
    } vec_t;

    vec_t tv[$];

    function automatic vec_t r(
        bit rst, logic [1:0] c, logic [7:0] st, logic [7:0] d,
        bit txv, logic [7:0] txd, bit rxr,
        bit cs, logic [2:0] a, bit rw, logic [7:0] dout,
        bit rxv, logic [7:0] rxd, bit txr
    );
        vec_t v;
        v.rst = rst; v.chan = c; v.stat = st; v.dat = d;
        v.txv = txv; v.txd = txd; v.rxr = rxr;
        v.e_cs_b = cs; v.e_addr = a; v.e_rdnw = rw; v.e_dout = dout;
        v.e_rxv = rxv; v.e_rxd = rxd; v.e_txr = txr;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [7:0] act,
                       input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", nm, act, exp);
        end
    endtask

    task automatic do_reset(input logic [1:0] c);
        p_rst    = 1'b1;
        chan     = c;
        stat_v   = 8'h00;
        dat_v    = 8'h00;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        rx_ready = 1'b0;
        #2;
        p_rst    = 1'b0;
    endtask

    task automatic step_count();
        @(posedge p_phi2);
        #1;
        if (!p_cs_b && p_addr[0] && p_rdnw) begin
            dat_v = 8'(8'hA0 + nreads);
            nreads++;
        end
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        p_irq_b  = 1'b0;
        p_rst    = 1'b1;
        chan     = 2'd0;
        stat_v   = 8'h00;
        dat_v    = 8'h00;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        rx_ready = 1'b0;
        #12;
        chk("rst cs_b", p_cs_b, 1);
        chk("rst rdnw", p_rdnw, 1);
        chk("rst addr", p_addr, 0);
        chk("rst dout", p_data_out, 0);
        chk("rst rxv", rx_valid, 0);
        chk("rst txr", tx_ready, 1);
        chk("rst busy", busy, 0);

        // idle polling, chan 0, status 0x00
        tv.push_back(r(1,0,8'h00,8'h00,0,0,0, 0,0,1,0,0,0,1));
        tv.push_back(r(0,0,8'h00,8'h00,0,0,0, 1,0,1,0,0,0,1));
        tv.push_back(r(0,0,8'h00,8'h00,0,0,0, 1,0,1,0,0,0,1));
        tv.push_back(r(0,0,8'h00,8'h00,0,0,0, 0,0,1,0,0,0,1));
        tv.push_back(r(0,0,8'h00,8'h00,0,0,0, 1,0,1,0,0,0,1));
        tv.push_back(r(0,0,8'h00,8'h00,0,0,0, 1,0,1,0,0,0,1));
        tv.push_back(r(0,0,8'h00,8'h00,0,0,0, 0,0,1,0,0,0,1));
        // single RX byte
        tv.push_back(r(1,0,8'h80,8'h5A,0,0,0, 0,0,1,0,0,0,1));
        tv.push_back(r(0,0,8'h00,8'h5A,0,0,0, 0,1,1,0,0,0,1));
        tv.push_back(r(0,0,8'h00,8'h00,0,0,0, 0,0,1,0,1,8'h5A,1));
        // single TX byte on chan 2
        tv.push_back(r(1,2,8'h40,8'h00,1,8'hC3,0, 0,4,1,0,0,0,1));
        tv.push_back(r(0,2,8'h40,8'h00,0,8'h00,0, 1,0,1,0,0,0,0));
        tv.push_back(r(0,2,8'h40,8'h00,0,8'h00,0, 1,0,1,0,0,0,0));
        tv.push_back(r(0,2,8'h40,8'h00,0,8'h00,0, 0,4,1,0,0,0,0));
        tv.push_back(r(0,2,8'h00,8'h00,0,8'h00,0, 0,5,0,8'hC3,0,0,0));
        tv.push_back(r(0,2,8'h00,8'h00,0,8'h00,0, 0,4,1,0,0,0,1));
        // both directions busy on chan 1, prio alternation
        tv.push_back(r(1,1,8'hC0,8'h22,1,8'h11,1, 0,2,1,0,0,0,1));
        tv.push_back(r(0,1,8'hC0,8'h22,1,8'h11,1, 0,3,1,0,0,0,0));
        tv.push_back(r(0,1,8'hC0,8'h22,1,8'h11,1, 0,2,1,0,1,8'h22,0));
        tv.push_back(r(0,1,8'hC0,8'h22,1,8'h11,1, 0,3,1,0,0,0,0));
        tv.push_back(r(0,1,8'hC0,8'h22,1,8'h11,1, 0,2,1,0,1,8'h22,0));
        tv.push_back(r(0,1,8'hC0,8'h22,1,8'h33,1, 0,3,0,8'h11,0,0,0));
        tv.push_back(r(0,1,8'hC0,8'h22,1,8'h33,1, 0,2,1,0,0,0,1));
        tv.push_back(r(0,1,8'hC0,8'h22,1,8'h33,1, 0,3,1,0,0,0,0));
        tv.push_back(r(0,1,8'hC0,8'h22,1,8'h33,1, 0,2,1,0,1,8'h22,0));
        tv.push_back(r(0,1,8'hC0,8'h22,1,8'h33,1, 0,3,1,0,0,0,0));
        tv.push_back(r(0,1,8'hC0,8'h22,1,8'h33,1, 0,2,1,0,1,8'h22,0));
        tv.push_back(r(0,1,8'h00,8'h22,0,8'h33,0, 0,3,0,8'h33,0,0,0));

        for (int i = 0; i < tv.size(); i++) begin
            if (tv[i].rst) do_reset(tv[i].chan);
            @(posedge p_phi2);
            #1;
            chk($sformatf("row%0d cs_b", i), p_cs_b, tv[i].e_cs_b);
            chk($sformatf("row%0d busy", i), busy, !tv[i].e_cs_b);
            chk($sformatf("row%0d rxv", i), rx_valid, tv[i].e_rxv);
            chk($sformatf("row%0d txr", i), tx_ready, tv[i].e_txr);
            if (!tv[i].e_cs_b) begin
                chk($sformatf("row%0d addr", i), p_addr, tv[i].e_addr);
                chk($sformatf("row%0d rdnw", i), p_rdnw, tv[i].e_rdnw);
                if (!tv[i].e_rdnw)
                    chk($sformatf("row%0d dout", i), p_data_out, tv[i].e_dout);
            end
            if (tv[i].e_rxv)
                chk($sformatf("row%0d rxd", i), rx_data, tv[i].e_rxd);
            chan     = tv[i].chan;
            stat_v   = tv[i].stat;
            dat_v    = tv[i].dat;
            tx_valid = tv[i].txv;
            tx_data  = tv[i].txd;
            rx_ready = tv[i].rxr;
        end

        // FIFO fills to depth, then one pop allows one more read
        do_reset(0);
        stat_v = 8'h80;
        nreads = 0;
        repeat (30) step_count();
        chk("full reads", 8'(nreads), 4);
        chk("full rxv", rx_valid, 1);
        chk("full head", rx_data, 8'hA0);
        rx_ready = 1'b1;
        step_count();
        rx_ready = 1'b0;
        repeat (20) step_count();
        chk("refill reads", 8'(nreads), 5);
        stat_v = 8'h00;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("drain%0d", k), rx_data, 8'(8'hA1 + k));
            rx_ready = 1'b1;
            @(posedge p_phi2);
            #1;
        end
        rx_ready = 1'b0;
        chk("drained rxv", rx_valid, 0);

        // asynchronous reset in the middle of a write
        do_reset(2);
        stat_v   = 8'hC0;
        dat_v    = 8'h77;
        tx_valid = 1'b1;
        tx_data  = 8'h5A;
        found    = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            @(posedge p_phi2);
            #1;
            if (!p_cs_b && !p_rdnw) found = 1'b1;
        end
        chk("wr reached", found, 1);
        chk("pre-rst rxv", rx_valid, 1);
        tx_valid = 1'b0;
        p_rst    = 1'b1;
        #1;
        chk("async cs_b", p_cs_b, 1);
        chk("async rdnw", p_rdnw, 1);
        chk("async txr", tx_ready, 1);
        chk("async rxv", rx_valid, 0);
        chk("async busy", busy, 0);

        // irq wake behaviour
        p_irq_b = 1'b1;
        do_reset(0);
`ifdef TUBE_IRQ_WAKE_EN
        acc = 0;
        repeat (20) begin
            @(posedge p_phi2);
            #1;
            if (!p_cs_b) acc++;
        end
        chk("sleep accesses", 8'(acc), 0);
        p_irq_b = 1'b0;
`endif
        found = 1'b0;
        for (int k = 0; k < 4 && !found; k++) begin
            @(posedge p_phi2);
            #1;
            if (!p_cs_b) found = 1'b1;
        end
        chk("poll after irq cfg", found, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tube_p_initiator.md
Name: tube_p_initiator

Overview:
- Parasite-side bus master for the Tube ULA register interface; the initiating end of the parasite bus.
- Issues one register access per p_phi2 cycle to a selected channel (1-4).
- Polls the channel status register and moves bytes:
  - host->parasite data into a local RX FIFO;
  - a local TX holding byte into the parasite->host register.
- Sits between a soft parasite core or test harness and the tube module's parasite port.

Parameters:
RX_DEPTH, 4, RX FIFO entries; power of two, >=2
IDLE_GAP, 2, idle cycles between polls after a no-work status read (0..15)

Ports:
p_phi2  input  1  sole clock, rising edge
p_rst  input  1  asynchronous active-high reset
chan  input  2  channel select, 0..3 = Tube reg 1..4; sampled in S_IDLE only
p_addr  output  3  parasite register address
p_cs_b  output  1  chip select, active low
p_rdnw  output  1  1=read, 0=write
p_data_out  output  8  write data to Tube
p_data_in  input  8  read data from Tube, valid during the access cycle
p_irq_b  input  1  parasite IRQ from Tube, active low
rx_data  output  8  FIFO head byte
rx_valid  output  1  FIFO non-empty
rx_ready  input  1  consumer pop strobe
tx_data  input  8  byte to send
tx_valid  input  1  TX offer
tx_ready  output  1  TX holding register empty
busy  output  1  state != S_IDLE

Behaviour:
- Clock and reset: one clock (p_phi2); reset p_rst is asynchronous, active-high.
- Reset values: state=S_IDLE, p_cs_b=1, p_rdnw=1, p_addr=0, p_data_out=0, FIFO empty (rx_valid=0), TX hold empty (tx_ready=1), prio=0, gap counter=0, busy=0.
- Reset mid-access: the cycle is abandoned. Any TX byte or RX byte in flight is dropped.
- Bus outputs are registered. While state==X, the bus carries X's access. Read data is captured at the rising edge that ends that cycle.
- Addresses: status = {chan_q,1'b0}; data = {chan_q,1'b1}. chan_q is latched on the S_IDLE->S_STAT transition.
- States:
  - S_IDLE:
    - cs_b=1.
    - Gap counter counts down to 0, then -> S_STAT.
    - After reset the counter is 0, so the first poll follows immediately.
  - S_STAT:
    - Read status. rx_ok = st[7] & fifo_count<RX_DEPTH; tx_ok = st[6] & hold_valid.
    - Both ok: prio=0 -> S_RD, prio=1 -> S_WR; prio toggles.
    - One ok: -> that state; prio is unchanged.
    - Neither: -> S_IDLE, gap counter loaded with IDLE_GAP.
  - S_RD: read the data register; push p_data_in into the FIFO at cycle end; -> S_STAT.
  - S_WR: write hold byte (p_rdnw=0, p_data_out=hold); clear hold_valid at cycle end; -> S_STAT.
- Back-to-back bursts are STAT/RD/STAT/RD...; there is no idle between work items.
- TX handshake:
  - tx_ready = !hold_valid. Accept on tx_valid & tx_ready.
  - hold_valid cleared at end of S_WR; tx_ready rises the following cycle.
- RX handshake:
  - Pop on rx_valid & rx_ready.
  - Simultaneous push+pop: count unchanged, order preserved.
  - FIFO full blocks rx_ok at S_STAT, so no overflow is possible.
  - Pop while empty is ignored.
- FIFO pointers wrap modulo RX_DEPTH. The count has log2(RX_DEPTH)+1 bits.
- Status bits [5:0] are ignored.

Optional Feature:
TUBE_IRQ_WAKE_EN
- Defined: S_IDLE leaves only when all three hold: the gap has expired, and p_irq_b==0 or hold_valid==1. The engine sleeps with cs_b=1 indefinitely otherwise.
- Undefined: p_irq_b is ignored and polling is continuous, as described above.

Decomposition:
- Package tube_init_pkg holds:
  - state enum: S_IDLE, S_STAT, S_RD, S_WR;
  - status bit indices: ST_AVAIL=7, ST_NOTFULL=6;
  - the channel-to-address helper.
- Sub-module tube_init_fifo: synchronous RX FIFO with push, pop, count, and head output.

Test Plan:
- Reset, chan=0, status reads 0x00 repeatedly -> accesses alternate STAT at addr 0 with 2 idle cycles between; busy pulses 1 cycle per poll; no data reads.
- chan=0, status 0x80, data 0x5A -> read at addr 0, then addr 1; rx_valid=1, rx_data=0x5A on the next cycle.
- chan=2, tx_data=0xC3 accepted, status 0x40 -> write of 0xC3 at addr 5 with p_rdnw=0; tx_ready returns to 1 the cycle after.
- Status 0xC0 continuously with TX always offered -> order STAT,RD,STAT,WR,STAT,RD... (prio alternates).
- RX_DEPTH=4, rx_ready=0, status 0x80 -> exactly 4 data reads, then STAT-only polling. A single pop -> one more read.
- p_rst asserted during S_WR -> p_cs_b=1 immediately (asynchronously), tx_ready=1, rx_valid=0. With TUBE_IRQ_WAKE_EN and p_irq_b=1, no access ever issues until p_irq_b=0.
